// File: rtl/nv_ram_rws_256x128_fifo_ctl.sv
// rtl/nv_ram_rws_256x128_fifo_ctl.sv - valid/ready FIFO sequencer around a 256x128 1R1W RAM
// Optional same-cycle bypass of an empty FIFO: NV_RAMCTL_FLOW_THRU_EN
module nv_ram_rws_256x128_fifo_ctl (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [127:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [127:0] rd_pd,
  output logic [8:0]   fifo_count,
  output logic         ram_we,
  output logic [7:0]   ram_wa,
  output logic [127:0] ram_di,
  output logic         ram_re,
  output logic [7:0]   ram_ra,
  input  logic [127:0] ram_dout,
  input  logic [31:0]  pwrbus_ram_pd,
  output logic [31:0]  ram_pwrbus_ram_pd
);

  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic [8:0] count;
  logic       out_vld;
  logic       push;
  logic       pop;
  logic       bypass;
  logic [8:0] unfetched;

  assign wr_prdy = (count != 9'd256);

`ifdef NV_RAMCTL_FLOW_THRU_EN
  // count==0 implies out_vld==0, so the RAM output is never presented here
  assign bypass  = (count == 9'd0) & wr_pvld & rd_prdy;
  assign rd_pvld = out_vld | ((count == 9'd0) & wr_pvld);
  assign rd_pd   = out_vld ? ram_dout : wr_pd;
`else
  assign bypass  = 1'b0;
  assign rd_pvld = out_vld;
  assign rd_pd   = ram_dout;
`endif

  assign push = wr_pvld & wr_prdy & ~bypass;
  assign pop  = out_vld & rd_prdy;

  assign ram_we = push;
  assign ram_wa = wr_ptr;
  assign ram_di = wr_pd;

  // Entries written but not yet fetched into the RAM read register
  assign unfetched = count - {8'd0, out_vld} + {8'd0, push};
  assign ram_re    = (unfetched != 9'd0) & (~out_vld | pop);
  assign ram_ra    = rd_ptr;

  assign fifo_count        = count;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr  <= 8'd0;
      rd_ptr  <= 8'd0;
      count   <= 9'd0;
      out_vld <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 8'd1;
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 9'd1;
        2'b01:   count <= count - 9'd1;
        default: count <= count;
      endcase
      if (ram_re) begin
        out_vld <= 1'b1;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_256x128_fifo_ctl.sv
// tb/tb_nv_ram_rws_256x128_fifo_ctl.sv - directed/scoreboard bench for nv_ram_rws_256x128_fifo_ctl
module tb_nv_ram_rws_256x128_fifo_ctl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [127:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [127:0] rd_pd;
  logic [8:0]   fifo_count;
  logic         ram_we;
  logic [7:0]   ram_wa;
  logic [127:0] ram_di;
  logic         ram_re;
  logic [7:0]   ram_ra;
  logic [127:0] ram_dout;
  logic [31:0]  pwrbus_ram_pd;
  logic [31:0]  ram_pwrbus_ram_pd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] q[$];
  logic [127:0] mem [0:255];

  always #5 clk = ~clk;

  nv_ram_rws_256x128_fifo_ctl dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rst_n),
    .wr_pvld          (wr_pvld),
    .wr_prdy          (wr_prdy),
    .wr_pd            (wr_pd),
    .rd_pvld          (rd_pvld),
    .rd_prdy          (rd_prdy),
    .rd_pd            (rd_pd),
    .fifo_count       (fifo_count),
    .ram_we           (ram_we),
    .ram_wa           (ram_wa),
    .ram_di           (ram_di),
    .ram_re           (ram_re),
    .ram_ra           (ram_ra),
    .ram_dout         (ram_dout),
    .pwrbus_ram_pd    (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd(ram_pwrbus_ram_pd)
  );

  // RAM beside the controller: write-first on same-address read/write, output held between reads
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= (ram_we && ram_wa == ram_ra) ? ram_di : mem[ram_ra];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge against the queue model, advance model
  task automatic cycle(input logic pv, input logic [127:0] pd, input logic rr);
    logic push;
    logic byp;
    wr_pvld = pv;
    wr_pd   = pd;
    rd_prdy = rr;
    @(negedge clk);
    byp = 1'b0;
`ifdef NV_RAMCTL_FLOW_THRU_EN
    byp = (q.size() == 0) && pv;
`endif
    push = pv && (q.size() != 256);
    check("wr_prdy", 128'(wr_prdy), 128'(q.size() != 256));
    check("fifo_count", 128'(fifo_count), 128'(q.size()));
    if (byp) begin
      check("rd_pvld_ft", 128'(rd_pvld), 128'(1));
      check("rd_pd_ft", rd_pd, pd);
      check("ram_we_ft", 128'(ram_we), 128'(!rr));
      if (!rr) q.push_back(pd);
    end else begin
      check("rd_pvld", 128'(rd_pvld), 128'(q.size() != 0));
      if (q.size() != 0) check("rd_pd", rd_pd, q[0]);
      check("ram_we", 128'(ram_we), 128'(push));
      if (q.size() == 0 && !pv) check("ram_re_idle", 128'(ram_re), 128'(0));
      if (rr && q.size() != 0) void'(q.pop_front());
      if (push) q.push_back(pd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle(1'b0, 128'd0, 1'b1);
    check("drained", 128'(q.size()), 128'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_pvld       = 1'b0;
    wr_pd         = 128'd0;
    rd_prdy       = 1'b0;
    pwrbus_ram_pd = 32'hA5C3_0F1E;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_pvld", 128'(rd_pvld), 128'(0));
    check("rst_wr_prdy", 128'(wr_prdy), 128'(1));
    check("rst_count", 128'(fifo_count), 128'(0));
    check("rst_ram_we", 128'(ram_we), 128'(0));
    check("rst_ram_re", 128'(ram_re), 128'(0));
    check("pwrbus", 128'(ram_pwrbus_ram_pd), 128'(32'hA5C3_0F1E));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word latency with consumer ready
    cycle(1'b1, 128'h1, 1'b1);
    cycle(1'b0, 128'd0, 1'b1);
    cycle(1'b0, 128'd0, 1'b1);

    // Fill to 256, then pop+push at full: push refused, ready returns next cycle
    for (int i = 0; i < 256; i++) cycle(1'b1, 128'(i) | (128'h100 << 64), 1'b0);
    check("full_count", 128'(fifo_count), 128'(256));
    check("full_prdy", 128'(wr_prdy), 128'(0));
    cycle(1'b1, 128'hDEAD, 1'b1);
    check("after_full_count", 128'(fifo_count), 128'(255));
    check("after_full_prdy", 128'(wr_prdy), 128'(1));
    drain();

    // 300 incrementing words across pointer wrap
    for (int i = 0; i < 200; i++) cycle(1'b1, 128'(1000 + i), 1'b0);
    drain();
    for (int i = 200; i < 300; i++) cycle(1'b1, 128'(1000 + i), 1'b0);
    drain();

    // Steady occupancy 5 with push+pop every cycle
    for (int i = 0; i < 5; i++) cycle(1'b1, 128'(5000 + i), 1'b0);
    for (int i = 5; i < 1005; i++) cycle(1'b1, 128'(5000 + i), 1'b1);
    check("steady_count", 128'(fifo_count), 128'(5));
    drain();

    // Random pressure: push 70%, pop 30%
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 99) < 70, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 99) < 30);
    drain();

    // Reset mid-stream with 100 entries
    for (int i = 0; i < 100; i++) cycle(1'b1, 128'(7000 + i), 1'b0);
    wr_pvld = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_rd_pvld", 128'(rd_pvld), 128'(0));
    check("midrst_count", 128'(fifo_count), 128'(0));
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 128'hABC, 1'b0);
    check("post_rst_first", rd_pd, 128'hABC);
    cycle(1'b0, 128'd0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
